// File: rtl/ula_sequencial_if.sv
// Operand/result bus of the sequential ALU: valid/ready on the operand side,
// valid/ready plus status flags on the result side.
interface ula_sequencial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] scr0;
    logic [WIDTH-1:0] scr1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;

    // Operand sequencer / result consumer side
    modport master (
        output in_valid, ctrl, scr0, scr1, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_c, flag_n, flag_v
    );

    // ALU side
    modport slave (
        input  in_valid, ctrl, scr0, scr1, out_ready,
        output in_ready, out_valid, result, flag_z, flag_c, flag_n, flag_v
    );
endinterface

// File: rtl/ula_sequencial.sv
// Sequential ALU: registered operands/results, valid/ready handshakes,
// status flags, single-cycle add/sub/logic ops, one-bit-per-cycle shifts
// and a shift-add multiplier. One operation in flight at a time.
module ula_sequencial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    ula_sequencial_if.slave    bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [WIDTH:0]   WIDTH_EXT = (WIDTH + 1)'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Signed overflow of a + b: same-sign operands giving a different-sign sum
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
    endfunction

    // Signed overflow of a - b: differing-sign operands, result sign != a sign
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] d);
        return ((a < 0) != (b < 0)) && ((d < 0) != (a < 0));
    endfunction

    // Control state (reset)
    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;

    // Datapath state (no reset; only meaningful while BUSY)
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] wide_q, wide_d;   // shift register / multiplicand
    logic [WIDTH-1:0]   b_q, b_d;         // multiplier, consumed LSB-first
    logic [2*WIDTH-1:0] acc_q, acc_d;     // product accumulator

    // Scratch values for the current cycle
    logic               fin;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c, fin_v;
    logic [WIDTH:0]     sum, diff;
    logic [CNT_W-1:0]   amt;
    logic [WIDTH-1:0]   sh_n;
    logic [2*WIDTH-1:0] acc_n;

    // Next-state, datapath step and result/flag capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        z_d         = z_q;
        c_d         = c_q;
        n_d         = n_q;
        v_d         = v_q;
        op_d        = op_q;
        wide_d      = wide_q;
        b_d         = b_q;
        acc_d       = acc_q;
        fin         = 1'b0;
        fin_res     = '0;
        fin_c       = 1'b0;
        fin_v       = 1'b0;
        sum         = {1'b0, bus.scr0} + {1'b0, bus.scr1};
        diff        = {1'b0, bus.scr0} - {1'b0, bus.scr1};
        amt         = ({1'b0, bus.scr1} >= WIDTH_EXT) ? CNT_FULL : CNT_W'(bus.scr1);
        sh_n        = '0;
        acc_n       = acc_q + (b_q[0] ? wide_q : '0);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d = bus.ctrl;
                    case (bus.ctrl)
                        OP_ADD: begin
                            fin     = 1'b1;
                            fin_res = sum[WIDTH-1:0];
                            fin_c   = sum[WIDTH];
                            fin_v   = add_ovf(bus.scr0, bus.scr1, sum[WIDTH-1:0]);
                        end
                        OP_SUB: begin
                            fin     = 1'b1;
                            fin_res = diff[WIDTH-1:0];
                            fin_c   = diff[WIDTH];
                            fin_v   = sub_ovf(bus.scr0, bus.scr1, diff[WIDTH-1:0]);
                        end
                        OP_AND: begin
                            fin     = 1'b1;
                            fin_res = bus.scr0 & bus.scr1;
                        end
                        OP_OR: begin
                            fin     = 1'b1;
                            fin_res = bus.scr0 | bus.scr1;
                        end
                        OP_XOR: begin
                            fin     = 1'b1;
                            fin_res = bus.scr0 ^ bus.scr1;
                        end
                        OP_SHL, OP_SHR: begin
                            if (amt == '0) begin
                                fin     = 1'b1;
                                fin_res = bus.scr0;
                            end else begin
                                wide_d  = {{WIDTH{1'b0}}, bus.scr0};
                                cnt_d   = amt;
                                state_d = S_BUSY;
                            end
                        end
                        default: begin
                            wide_d  = {{WIDTH{1'b0}}, bus.scr0};
                            b_d     = bus.scr1;
                            acc_d   = '0;
                            cnt_d   = CNT_FULL;
                            state_d = S_BUSY;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d   = acc_n;
                    wide_d  = wide_q << 1;
                    b_d     = b_q >> 1;
                    fin_res = acc_n[WIDTH-1:0];
                    fin_c   = |acc_n[2*WIDTH-1:WIDTH];
                end else begin
                    if (op_q == OP_SHL) begin
                        sh_n  = wide_q[WIDTH-1:0] << 1;
                        fin_c = wide_q[WIDTH-1];
                    end else begin
                        sh_n  = wide_q[WIDTH-1:0] >> 1;
                        fin_c = wide_q[0];
                    end
                    wide_d  = {{WIDTH{1'b0}}, sh_n};
                    fin_res = sh_n;
                end
                fin = (cnt_q == CNT_ONE);
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (fin) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = fin_res;
            z_d      = (fin_res == '0);
            c_d      = fin_c;
            n_d      = fin_res[WIDTH-1];
            v_d      = fin_v;
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // FSM and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            z_q         <= z_d;
            c_q         <= c_d;
            n_q         <= n_d;
            v_q         <= v_d;
        end
    end

    // Iteration datapath registers
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        wide_q <= wide_d;
        b_q    <= b_d;
        acc_q  <= acc_d;
    end

    assign bus.in_ready  = in_ready_q & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_v    = v_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed bench for ula_sequencial (WIDTH=8): arithmetic, logic, shift and
// multiply vectors with hand-computed results, backpressure and mid-op reset.
module tb_ula_sequencial;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    ula_sequencial_if #(.WIDTH(W)) bus ();

    ula_sequencial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one op, measure latency, check result and flags {z,c,n,v};
    // optionally release the result with a one-cycle out_ready pulse.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input logic [W-1:0] exp_res,
                          input logic [3:0] exp_flags, input bit release_it);
        int lat;
        @(negedge clk);
        chk_b({tag, ".in_ready_idle"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.ctrl     = op;
        bus.scr0     = a;
        bus.scr1     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            chk_b({tag, ".in_ready_busy"}, bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk_b({tag, ".out_valid"}, bus.out_valid, 1'b1);
        chk_i({tag, ".latency"}, lat, exp_lat);
        chk_w({tag, ".result"}, bus.result, exp_res);
        chk_w({tag, ".flags_zcnv"},
              {4'b0, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v},
              {4'b0, exp_flags});
        if (release_it) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            chk_b({tag, ".out_valid_clr"}, bus.out_valid, 1'b0);
            chk_b({tag, ".in_ready_back"}, bus.in_ready, 1'b1);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.ctrl      = 3'b000;
        bus.scr0      = '0;
        bus.scr1      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_b("rst.in_ready", bus.in_ready, 1'b0);
        chk_b("rst.out_valid", bus.out_valid, 1'b0);
        chk_w("rst.result", bus.result, 8'h00);
        chk_w("rst.flags", {4'b0, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_b("rst.in_ready_after", bus.in_ready, 1'b1);

        // Single-cycle ops                       flags = {z,c,n,v}
        run_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 1, 8'h80, 4'b0011, 1'b1);
        run_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 1, 8'h00, 4'b1100, 1'b1);
        run_op("sub_00_02", 3'b001, 8'h00, 8'h02, 1, 8'hFE, 4'b0110, 1'b1);
        run_op("sub_80_01", 3'b001, 8'h80, 8'h01, 1, 8'h7F, 4'b0001, 1'b1);
        run_op("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000, 1'b1);
        run_op("or_80_01",  3'b011, 8'h80, 8'h01, 1, 8'h81, 4'b0010, 1'b1);
        run_op("xor_aa_aa", 3'b100, 8'hAA, 8'hAA, 1, 8'h00, 4'b1000, 1'b1);

        // Multiplier
        run_op("mul_10_11", 3'b111, 8'h10, 8'h11, 9, 8'h10, 4'b0100, 1'b1);
        run_op("mul_0f_0f", 3'b111, 8'h0F, 8'h0F, 9, 8'hE1, 4'b0010, 1'b1);

        // Shifts
        run_op("shl_81_1", 3'b101, 8'h81, 8'd1, 2, 8'h02, 4'b0100, 1'b1);
        run_op("shr_83_9", 3'b110, 8'h83, 8'd9, 9, 8'h00, 4'b1100, 1'b1);
        run_op("shl_55_0", 3'b101, 8'h55, 8'd0, 1, 8'h55, 4'b0000, 1'b1);
        run_op("shr_81_3", 3'b110, 8'h81, 8'd3, 4, 8'h10, 4'b0000, 1'b1);
        run_op("shl_81_8", 3'b101, 8'h81, 8'd8, 9, 8'h00, 4'b1100, 1'b1);

        // Backpressure: result held, new requests ignored
        run_op("bp_add", 3'b000, 8'h12, 8'h34, 1, 8'h46, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2) == 0;
            bus.ctrl     = 3'b111;
            bus.scr0     = 8'hFF;
            bus.scr1     = 8'hFF;
            @(posedge clk);
            #1;
            chk_b("bp.out_valid", bus.out_valid, 1'b1);
            chk_b("bp.in_ready", bus.in_ready, 1'b0);
            chk_w("bp.result", bus.result, 8'h46);
            chk_w("bp.flags", {4'b0, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v}, 8'h00);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk_b("bp.release_out_valid", bus.out_valid, 1'b0);
        chk_b("bp.release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk_b("bp.no_new_op", bus.out_valid, 1'b0);

        // Reset during a multiply
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ctrl     = 3'b111;
        bus.scr0     = 8'h0F;
        bus.scr1     = 8'h0F;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_b("mrst.out_valid", bus.out_valid, 1'b0);
        chk_w("mrst.result", bus.result, 8'h00);
        chk_w("mrst.flags", {4'b0, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v}, 8'h00);
        chk_b("mrst.in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk_b("mrst.no_stale", bus.out_valid, 1'b0);
        end
        run_op("post_rst_add", 3'b000, 8'h01, 8'h02, 1, 8'h03, 4'b0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
